// File: rtl/cmp_pkg.sv
// Shared opcode type and helpers for the cmp_pipe pipelined magnitude comparator.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_ULT = 3'b000,
        OP_ULE = 3'b001,
        OP_UGT = 3'b010,
        OP_UGE = 3'b011,
        OP_EQ  = 3'b100,
        OP_NE  = 3'b101,
        OP_SLT = 3'b110,
        OP_SGE = 3'b111
    } op_t;

    function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // c is the carry out of A + ~B + 1 (set when A >= B); eq is the accumulated chunk equality.
    function automatic logic cmp_decode(input op_t op, input logic c, input logic eq);
        logic res;
        res = 1'b0;
        case (op)
            OP_ULT, OP_SLT: res = ~c;
            OP_ULE:         res = ~c | eq;
            OP_UGT:         res = c & ~eq;
            OP_UGE, OP_SGE: res = c;
            OP_EQ:          res = eq;
            OP_NE:          res = ~eq;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_stage.sv
// One carry-chain pipeline stage of cmp_pipe: adds operand bits [LO +: W] of A and ~B
// onto the incoming carry and folds chunk equality into the running eq flag.
module cmp_stage
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LO    = 0,
    parameter int unsigned W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] nb_i,
    input  logic             c_i,
    input  logic             eq_i,
    input  op_t              op_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] nb_o,
    output logic             c_o,
    output logic             eq_o,
    output op_t              op_o
);

    logic [W-1:0]     a_chunk;
    logic [W-1:0]     nb_chunk;
    logic             c_next;
    logic             eq_next;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             c_q, c_d;
    logic             eq_q, eq_d;
    op_t              op_q, op_d;

    assign a_chunk  = a_i[LO +: W];
    assign nb_chunk = nb_i[LO +: W];
    assign c_next   = 1'(((W+1)'(a_chunk) + (W+1)'(nb_chunk) + (W+1)'(c_i)) >> W);
    assign eq_next  = eq_i & (a_chunk == ~nb_chunk);

    // Bubbles advance the valid bit only, so the last real result stays visible downstream.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        nb_d    = nb_q;
        c_d     = c_q;
        eq_d    = eq_q;
        op_d    = op_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                a_d  = a_i;
                nb_d = nb_i;
                c_d  = c_next;
                eq_d = eq_next;
                op_d = op_i;
            end
        end
    end

    // Reset leaves ULT with carry set so an idle final stage decodes to O=0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            nb_q    <= '0;
            c_q     <= 1'b1;
            eq_q    <= 1'b0;
            op_q    <= OP_ULT;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            c_q     <= c_d;
            eq_q    <= eq_d;
            op_q    <= op_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign nb_o    = nb_q;
    assign c_o     = c_q;
    assign eq_o    = eq_q;
    assign op_o    = op_q;

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined multi-mode magnitude comparator: A - B as A + ~B + 1 split into CHUNK-bit stages.
// Define CMP_SIGNED_EN to enable two's-complement SLT/SGE; otherwise they act as ULT/UGE.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             VALID_IN,
    output logic             READY,
    output logic             O,
    output logic             VALID,
    input  logic             READY_IN
);

    localparam int unsigned STAGES = stages(WIDTH, CHUNK);

    logic             adv;
    op_t              op_in;
    logic [WIDTH-1:0] a_p  [STAGES+1];
    logic [WIDTH-1:0] nb_p [STAGES+1];
    logic [STAGES:0]  v_p;
    logic [STAGES:0]  c_p;
    logic [STAGES:0]  eq_p;
    op_t  [STAGES:0]  op_p;

    assign op_in = op_t'(OP);

`ifdef CMP_SIGNED_EN
    // Flipping both MSBs maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] msb_flip;
    assign msb_flip = {(op_in == OP_SLT) || (op_in == OP_SGE), {(WIDTH-1){1'b0}}};
    assign a_p[0]   = A ^ msb_flip;
    assign nb_p[0]  = ~(B ^ msb_flip);
`else
    assign a_p[0]   = A;
    assign nb_p[0]  = ~B;
`endif

    assign v_p[0]  = VALID_IN;
    assign c_p[0]  = 1'b1;
    assign eq_p[0] = 1'b1;
    assign op_p[0] = op_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = CHUNK * k;
        localparam int unsigned W  = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;

        cmp_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .W     (W)
        ) u_stage (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .en_i    (adv),
            .valid_i (v_p[k]),
            .a_i     (a_p[k]),
            .nb_i    (nb_p[k]),
            .c_i     (c_p[k]),
            .eq_i    (eq_p[k]),
            .op_i    (op_p[k]),
            .valid_o (v_p[k+1]),
            .a_o     (a_p[k+1]),
            .nb_o    (nb_p[k+1]),
            .c_o     (c_p[k+1]),
            .eq_o    (eq_p[k+1]),
            .op_o    (op_p[k+1])
        );
    end

    // Whole pipeline moves as one; O is a pure decode of the final stage's flops.
    assign adv   = ~v_p[STAGES] | READY_IN;
    assign READY = adv;
    assign VALID = v_p[STAGES];
    assign O     = cmp_decode(op_p[STAGES], c_p[STAGES], eq_p[STAGES]);

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: an 8-bit/4-bit-chunk instance and a 10-bit/4-bit-chunk
// instance (partial final chunk), directed vectors, a stall sequence, random streams, reset.
module tb_cmp_pipe;

`ifdef CMP_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a8, b8;
    logic [2:0] op8;
    logic       vin8, rin8, rdy8, o8, v8;
    logic [9:0] a10, b10;
    logic [2:0] op10;
    logic       vin10, rin10, rdy10, o10, v10;

    int total = 0;
    int bad   = 0;
    logic q8[$];
    logic q10[$];
    int   pops8  = 0;
    int   pops10 = 0;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .CLK(clk), .RESET(rst), .A(a8), .B(b8), .OP(op8), .VALID_IN(vin8),
        .READY(rdy8), .O(o8), .VALID(v8), .READY_IN(rin8)
    );

    cmp_pipe #(.WIDTH(10), .CHUNK(4)) u_dut10 (
        .CLK(clk), .RESET(rst), .A(a10), .B(b10), .OP(op10), .VALID_IN(vin10),
        .READY(rdy10), .O(o10), .VALID(v10), .READY_IN(rin10)
    );

    typedef struct {
        bit         sel;
        logic [2:0] op;
        logic [9:0] a;
        logic [9:0] b;
        logic       exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Reference: compare integer values directly, reinterpreting as signed for SLT/SGE.
    function automatic logic model(input logic [2:0] op, input int w, input logic [9:0] a,
                                   input logic [9:0] b);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (SGN && op[2] && op[1]) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        case (op)
            3'd0, 3'd6: return sa < sb;
            3'd1:       return sa <= sb;
            3'd2:       return sa > sb;
            3'd3, 3'd7: return sa >= sb;
            3'd4:       return sa == sb;
            default:    return sa != sb;
        endcase
    endfunction

    task automatic set_in(input bit sel, input logic vin, input logic [9:0] a, input logic [9:0] b,
                          input logic [2:0] op, input logic rin);
        if (sel) begin
            vin10 = vin; a10 = a; b10 = b; op10 = op; rin10 = rin;
        end else begin
            vin8 = vin; a8 = a[7:0]; b8 = b[7:0]; op8 = op; rin8 = rin;
        end
    endtask

    function automatic logic get_v(input bit sel);
        return sel ? v10 : v8;
    endfunction
    function automatic logic get_o(input bit sel);
        return sel ? o10 : o8;
    endfunction
    function automatic logic get_rdy(input bit sel);
        return sel ? rdy10 : rdy8;
    endfunction

    // Call right after a negedge: drive, then sample 1 time unit before the next rising edge.
    task automatic drive_sample(input bit sel, input logic vin, input logic [9:0] a,
                                input logic [9:0] b, input logic [2:0] op, input logic rin,
                                output bit acc);
        logic [9:0] am, bm;
        logic       e;
        am = sel ? a : {2'b00, a[7:0]};
        bm = sel ? b : {2'b00, b[7:0]};
        set_in(sel, vin, am, bm, op, rin);
        #4;
        acc = vin && get_rdy(sel);
        if (acc) begin
            if (sel) q10.push_back(model(op, 10, am, bm));
            else     q8.push_back(model(op, 8, am, bm));
        end
        if (get_v(sel) && rin) begin
            if ((sel ? q10.size() : q8.size()) == 0) begin
                check($sformatf("stream%0d_unexpected_result", sel), 1, 0);
            end else begin
                e = sel ? q10.pop_front() : q8.pop_front();
                if (sel) pops10++;
                else     pops8++;
                check($sformatf("stream%0d_o", sel), get_o(sel), e);
            end
        end
    endtask

    // One isolated transfer; checks acceptance, exact latency and the result bit.
    task automatic apply_one(input int idx, input vec_t t);
        int edges;
        bit seen;
        @(negedge clk);
        set_in(t.sel, 1'b1, t.a, t.b, t.op, 1'b1);
        #4;
        check($sformatf("vec%0d_ready", idx), get_rdy(t.sel), 1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 8) begin
            @(negedge clk);
            set_in(t.sel, 1'b0, t.a, t.b, t.op, 1'b1);
            edges++;
            #4;
            seen = get_v(t.sel);
        end
        check($sformatf("vec%0d_latency", idx), edges, t.sel ? 3 : 2);
        check($sformatf("vec%0d_o", idx), get_o(t.sel), t.exp);
    endtask

    initial begin
        vec_t vt[$];
        vec_t sv[4];
        bit   acc;
        int   idx, stall;
        logic ho;

        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        vec_t sv[4];
        bit   acc;
        int   idx;
        int   stall;
        logic ho;

        rst = 1'b1;
        set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
        set_in(1'b1, 1'b0, '0, '0, 3'd0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst8_valid", v8, 0);
        check("rst8_o", o8, 0);
        check("rst8_ready", rdy8, 1);
        check("rst10_valid", v10, 0);
        check("rst10_o", o10, 0);
        check("rst10_ready", rdy10, 1);

        vt.push_back('{1'b0, 3'd0, 10'h003, 10'h005, 1'b1});        // ULT 3<5
        vt.push_back('{1'b0, 3'd3, 10'h003, 10'h005, 1'b0});        // UGE
        vt.push_back('{1'b0, 3'd1, 10'h000, 10'h000, 1'b1});        // ULE equal
        vt.push_back('{1'b0, 3'd0, 10'h000, 10'h000, 1'b0});        // ULT equal
        vt.push_back('{1'b0, 3'd4, 10'h000, 10'h000, 1'b1});        // EQ
        vt.push_back('{1'b0, 3'd2, 10'h0FF, 10'h000, 1'b1});        // UGT max
        vt.push_back('{1'b0, 3'd5, 10'h080, 10'h07F, 1'b1});        // NE
        vt.push_back('{1'b0, 3'd1, 10'h005, 10'h003, 1'b0});        // ULE 5<=3
        vt.push_back('{1'b0, 3'd2, 10'h034, 10'h034, 1'b0});        // UGT equal
        vt.push_back('{1'b0, 3'd4, 10'h035, 10'h034, 1'b0});        // EQ low chunk differs
        vt.push_back('{1'b0, 3'd6, 10'h0FF, 10'h001, SGN});         // SLT -1<1
        vt.push_back('{1'b0, 3'd7, 10'h0FF, 10'h001, !SGN});        // SGE
        vt.push_back('{1'b0, 3'd6, 10'h001, 10'h0FF, !SGN});        // SLT 1<-1
        vt.push_back('{1'b0, 3'd6, 10'h080, 10'h07F, SGN});         // SLT -128<127
        vt.push_back('{1'b1, 3'd2, 10'h200, 10'h1FF, 1'b1});        // UGT partial chunk
        vt.push_back('{1'b1, 3'd2, 10'h1FF, 10'h200, 1'b0});
        vt.push_back('{1'b1, 3'd4, 10'h3FF, 10'h3FF, 1'b1});
        vt.push_back('{1'b1, 3'd5, 10'h3FF, 10'h3FE, 1'b1});
        vt.push_back('{1'b1, 3'd6, 10'h200, 10'h1FF, SGN});         // SLT -512<511
        foreach (vt[i]) apply_one(i, vt[i]);

        @(negedge clk);
        set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
        set_in(1'b1, 1'b0, '0, '0, 3'd0, 1'b1);
        repeat (4) @(negedge clk);

        // Four back-to-back transfers with a 3-cycle downstream stall once VALID rises.
        sv[0] = '{1'b0, 3'd0, 10'h003, 10'h005, 1'b1};
        sv[1] = '{1'b0, 3'd3, 10'h003, 10'h005, 1'b0};
        sv[2] = '{1'b0, 3'd4, 10'h042, 10'h042, 1'b1};
        sv[3] = '{1'b0, 3'd2, 10'h010, 10'h020, 1'b0};
        idx   = 0;
        stall = 0;
        ho    = 1'b0;
        pops8 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (idx == 4 && q8.size() == 0) break;
            if (v8 && stall < 3) begin
                drive_sample(1'b0, idx < 4, sv[idx < 4 ? idx : 0].a, sv[idx < 4 ? idx : 0].b,
                             sv[idx < 4 ? idx : 0].op, 1'b0, acc);
                check($sformatf("stall%0d_ready", stall), rdy8, 0);
                check($sformatf("stall%0d_valid", stall), v8, 1);
                if (stall == 0) ho = o8;
                else            check($sformatf("stall%0d_o_hold", stall), o8, ho);
                stall++;
            end else begin
                drive_sample(1'b0, idx < 4, sv[idx < 4 ? idx : 0].a, sv[idx < 4 ? idx : 0].b,
                             sv[idx < 4 ? idx : 0].op, 1'b1, acc);
            end
            if (acc) idx++;
        end
        check("stall_accepted", idx, 4);
        check("stall_results", pops8, 4);
        check("stall_cycles", stall, 3);

        // Random streams with random back-pressure against the reference model.
        for (int s = 0; s < 2; s++) begin
            if (s == 0) pops8 = 0;
            else        pops10 = 0;
            for (int c = 0; c < 300; c++) begin
                logic [9:0] ra, rb;
                ra = 10'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? ra : 10'($urandom);
                @(negedge clk);
                drive_sample(s[0], $urandom_range(0, 3) != 0, ra, rb, 3'($urandom),
                             $urandom_range(0, 3) != 0, acc);
            end
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                drive_sample(s[0], 1'b0, '0, '0, 3'd0, 1'b1, acc);
            end
            check($sformatf("stream%0d_drained", s), s ? q10.size() : q8.size(), 0);
            check($sformatf("stream%0d_enough", s), (s ? pops10 : pops8) > 50, 1);
        end

        // Reset with two transactions in flight on the 8-bit instance.
        @(negedge clk);
        set_in(1'b0, 1'b1, 10'h003, 10'h005, 3'd0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b1, 10'h009, 10'h002, 3'd2, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, '0, '0, 3'd0, 1'b1);
        #4;
        check("prerst_valid", v8, 1);
        check("prerst_o", o8, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("midrst_valid", v8, 0);
        check("midrst_o", o8, 0);
        check("midrst_ready", rdy8, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #4;
            check($sformatf("postrst%0d_valid", c), v8, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
